pipe_shift_register: RTL and testbench
======================================

Name: pipe_shift_register

Overview:
- Parametrised scrolling shift register for the obstacle/pipe column map, generalising the fixed 40-bit version.
- Adds an internal scroll-rate prescaler, parallel load, selectable fill mode (serial, rotate, pseudo-random, hold), shift strobe and shift counter.
- Sits between the game-tick generator and the pipe renderer/collision logic.

Parameters:
- WIDTH, 40, register length in bits (>= 2).
- DIV_W, 8, prescaler counter width.
- COUNT_W, 16, shift counter width.
- LFSR_SEED, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'h0001.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous, active-low reset.
- shift_en  in  1  game-tick pulse, one clk wide, fed to the prescaler.
- div_ratio  in  DIV_W  shift once per (div_ratio+1) shift_en pulses.
- mode  in  2  fill select: 00 serial, 01 rotate, 10 LFSR, 11 hold.
- load  in  1  parallel load strobe.
- load_data  in  WIDTH  parallel load value.
- data_in  in  1  serial fill bit (mode 00).
- bit_out  out  1  bit shifted out of the MSB on the last shift (registered).
- par_out  out  WIDTH  register contents.
- shift_strobe  out  1  one-cycle pulse, asserted the cycle after a shift is committed.
- shift_count  out  COUNT_W  number of shifts since reset or load; wraps.

Behaviour:
- Reset: clk is the clock; resetn is a synchronous, active-low reset.
- While resetn=0 at a clk edge, the following are cleared and reset overrides all other inputs:
  - par_out=0, bit_out=0, shift_strobe=0, shift_count=0.
  - Internal div_cnt=0; LFSR=LFSR_SEED (0 is replaced by 16'h0001).
- Priority per clk edge: reset > load > shift > idle.
- Load (load=1):
  - par_out<=load_data, div_cnt<=0, shift_count<=0, bit_out<=0, shift_strobe<=0.
  - Any shift_en in the same cycle is discarded.
- Prescaler (load=0, mode!=11, shift_en=1):
  - If div_cnt >= div_ratio: commit a shift and set div_cnt<=0.
  - Otherwise div_cnt<=div_cnt+1.
  - The >= compare means lowering div_ratio below the current div_cnt shifts on the next pulse.
  - div_ratio=0 shifts on every pulse.
- Shift commit:
  - par_out<={par_out[WIDTH-2:0], fill}; bit_out<=par_out[WIDTH-1].
  - shift_strobe<=1 for exactly one cycle; shift_count<=shift_count+1, wrapping modulo 2^COUNT_W.
- Fill bit by mode:
  - 00: data_in.
  - 01: par_out[WIDTH-1] (rotate).
  - 10: lfsr[0].
- Hold (mode 11): shift_en is ignored, div_cnt is frozen, outputs hold; load still works.
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1, mask 16'hB400.
  - Steps as lfsr<=(lfsr>>1)^(lfsr[0]?16'hB400:0), only when a shift commits in mode 10.
  - Never reaches 0.
- A mode change takes effect on the next commit; div_cnt is not cleared by a mode change.
- With no shift committed, bit_out and par_out hold and shift_strobe=0.
- Latency: shift_en to par_out update is 1 clk on the committing pulse.

Optional Feature:
- Macro PIPE_SR_LFSR_EN.
- Defined: mode 10 uses the internal LFSR as described.
- Undefined: no LFSR register is built; mode 10 behaves exactly as mode 00 (fill=data_in); LFSR_SEED is ignored.

Test Plan:
- Reset: resetn=0 for 2 clk with load=1, load_data=all-ones, shift_en=1 -> par_out=0, bit_out=0, shift_strobe=0, shift_count=0.
- Serial, div_ratio=0, mode=00, data_in=1, 3 shift_en pulses from 0 -> par_out=40'h7, 3 strobes, shift_count=3, bit_out=0.
- Prescaler: div_ratio=3, 8 shift_en pulses -> shifts only on pulses 4 and 8, shift_count=2. Then set div_ratio=0 with div_cnt=2 -> next pulse shifts.
- Rotate: load 40'h80_0000_0001, mode=01, one shift -> par_out=40'h00_0000_0003, bit_out=1. Mode 11 with 5 pulses -> no change, no strobe.
- Load/shift collision: load=1 with shift_en=1, div_ratio=0 -> par_out=load_data, no strobe, shift_count=0.
- LFSR (macro defined), seed 16'hACE1, mode=10, 16 shifts -> par_out[15:0] matches the reference model's 16 successive lfsr[0] values, MSB-first order. Macro undefined, same stimulus with data_in=0 -> par_out=0.

Source files
------------

// File: rtl/pipe_shift_register.sv
// pipe_shift_register: prescaled scrolling pipe-map register with parallel load, fill modes and shift counter.
// Define PIPE_SR_LFSR_EN to build the LFSR fill source for mode 2'b10; otherwise mode 2'b10 fills from data_in.
module pipe_shift_register #(
    parameter int          WIDTH     = 40,
    parameter int          DIV_W     = 8,
    parameter int          COUNT_W   = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               shift_en,
    input  logic [DIV_W-1:0]   div_ratio,
    input  logic [1:0]         mode,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_data,
    input  logic               data_in,
    output logic               bit_out,
    output logic [WIDTH-1:0]   par_out,
    output logic               shift_strobe,
    output logic [COUNT_W-1:0] shift_count
);

    logic [WIDTH-1:0]   par_q, par_d;
    logic               bit_q, bit_d;
    logic               strobe_q, strobe_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               pulse, commit, fill, lfsr_bit;

`ifdef PIPE_SR_LFSR_EN
    localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = (commit && mode == 2'b10) ? ((lfsr_q >> 1) ^ (lfsr_q[0] ? 16'hB400 : 16'h0000)) : lfsr_q;
    end

    always_ff @(posedge clk) begin
        if (!resetn) lfsr_q <= SEED;
        else         lfsr_q <= lfsr_d;
    end

    assign lfsr_bit = lfsr_q[0];
`else
    logic unused_seed;
    assign unused_seed = ^LFSR_SEED;
    assign lfsr_bit    = data_in;
`endif

    // hold mode freezes the prescaler, so only non-hold pulses count
    always_comb begin
        pulse    = !load && mode != 2'b11 && shift_en;
        commit   = pulse && div_q >= div_ratio;
        fill     = (mode == 2'b01) ? par_q[WIDTH-1] : (mode == 2'b10) ? lfsr_bit : data_in;
        par_d    = load ? load_data : commit ? {par_q[WIDTH-2:0], fill} : par_q;
        bit_d    = load ? 1'b0 : commit ? par_q[WIDTH-1] : bit_q;
        strobe_d = commit;
        count_d  = load ? '0 : commit ? count_q + COUNT_W'(1) : count_q;
        div_d    = (load || commit) ? '0 : pulse ? div_q + DIV_W'(1) : div_q;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            par_q    <= '0;
            bit_q    <= 1'b0;
            strobe_q <= 1'b0;
            count_q  <= '0;
            div_q    <= '0;
        end else begin
            par_q    <= par_d;
            bit_q    <= bit_d;
            strobe_q <= strobe_d;
            count_q  <= count_d;
            div_q    <= div_d;
        end
    end

    assign par_out      = par_q;
    assign bit_out      = bit_q;
    assign shift_strobe = strobe_q;
    assign shift_count  = count_q;

endmodule

// File: tb/tb_pipe_shift_register.sv
// tb_pipe_shift_register: directed stimulus, per-cycle compare against a behavioural model plus literal checks.
module tb_pipe_shift_register;
    localparam int W = 40;

    logic          clk = 1'b0;
    logic          resetn, shift_en, load, data_in;
    logic [7:0]    div_ratio;
    logic [1:0]    mode;
    logic [W-1:0]  load_data;
    logic          bit_out, shift_strobe;
    logic [W-1:0]  par_out;
    logic [15:0]   shift_count;

    int checks = 0;
    int errors = 0;
    int n_stb  = 0;
    bit chk_en = 1'b0;

    logic [W-1:0] m_par;
    logic         m_bit, m_stb;
    int           m_cnt, m_pulses;
    logic [15:0]  m_lfsr;

`ifdef PIPE_SR_LFSR_EN
    localparam bit LFSR_ON = 1'b1;
`else
    localparam bit LFSR_ON = 1'b0;
`endif

    pipe_shift_register dut (
        .clk(clk), .resetn(resetn), .shift_en(shift_en), .div_ratio(div_ratio), .mode(mode),
        .load(load), .load_data(load_data), .data_in(data_in), .bit_out(bit_out),
        .par_out(par_out), .shift_strobe(shift_strobe), .shift_count(shift_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: count pulses since the last shift; a shift happens once that count reaches div_ratio.
    task automatic model_edge();
        logic f;
        if (!resetn) begin
            m_par = '0; m_bit = 0; m_stb = 0; m_cnt = 0; m_pulses = 0; m_lfsr = 16'hACE1;
        end else if (load) begin
            m_par = load_data; m_bit = 0; m_stb = 0; m_cnt = 0; m_pulses = 0;
        end else if (mode != 2'b11 && shift_en) begin
            if (m_pulses >= int'(div_ratio)) begin
                f = (mode == 2'b01) ? m_par[W-1] : (mode == 2'b10 && LFSR_ON) ? m_lfsr[0] : data_in;
                m_bit = m_par[W-1];
                m_par = (m_par << 1) | W'(f);
                m_cnt = (m_cnt + 1) % 65536;
                m_stb = 1;
                m_pulses = 0;
                if (mode == 2'b10 && LFSR_ON)
                    m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
            end else begin
                m_pulses++;
                m_stb = 0;
            end
        end else begin
            m_stb = 0;
        end
    endtask

    task automatic tick(input logic se, input logic ld);
        shift_en = se;
        load = ld;
        @(posedge clk);
        #1;
        model_edge();
    endtask

    always @(negedge clk) begin
        if (shift_strobe === 1'b1) n_stb++;
        if (chk_en) begin
            chk("model par_out", 64'(par_out), 64'(m_par));
            chk("model bit_out", 64'(bit_out), 64'(m_bit));
            chk("model shift_strobe", 64'(shift_strobe), 64'(m_stb));
            chk("model shift_count", 64'(shift_count), 64'(m_cnt));
        end
    end

    initial begin
        int s0;
        resetn = 0; load = 1; load_data = '1; shift_en = 1; data_in = 1; div_ratio = 0; mode = 0;
        tick(1, 1);
        chk_en = 1;
        tick(1, 1);
        chk("reset par_out", 64'(par_out), 64'h0);
        chk("reset bit_out", 64'(bit_out), 64'h0);
        chk("reset strobe", 64'(shift_strobe), 64'h0);
        chk("reset count", 64'(shift_count), 64'h0);

        resetn = 1; data_in = 1; div_ratio = 0; mode = 2'b00;
        s0 = n_stb;
        repeat (3) tick(1, 0);
        tick(0, 0);
        chk("serial par_out", 64'(par_out), 64'h7);
        chk("serial count", 64'(shift_count), 64'd3);
        chk("serial bit_out", 64'(bit_out), 64'h0);
        chk("serial strobes", 64'(n_stb - s0), 64'd3);

        load_data = '0; data_in = 0; div_ratio = 3;
        tick(0, 1);
        repeat (3) tick(1, 0);
        chk("prescale no shift yet", 64'(shift_count), 64'd0);
        tick(1, 0);
        chk("prescale 4th pulse", 64'(shift_count), 64'd1);
        repeat (4) tick(1, 0);
        chk("prescale 8 pulses", 64'(shift_count), 64'd2);
        repeat (2) tick(1, 0);
        div_ratio = 0;
        tick(1, 0);
        chk("prescale lowered ratio", 64'(shift_count), 64'd3);

        load_data = 40'h80_0000_0001;
        tick(0, 1);
        mode = 2'b01;
        tick(1, 0);
        chk("rotate par_out", 64'(par_out), 64'h3);
        chk("rotate bit_out", 64'(bit_out), 64'h1);
        mode = 2'b11;
        tick(0, 0);
        s0 = n_stb;
        repeat (5) tick(1, 0);
        tick(0, 0);
        chk("hold par_out", 64'(par_out), 64'h3);
        chk("hold count", 64'(shift_count), 64'd1);
        chk("hold strobes", 64'(n_stb - s0), 64'd0);

        mode = 2'b00; div_ratio = 0; load_data = 40'h12_3456_789A;
        tick(1, 1);
        chk("collision par_out", 64'(par_out), 64'h12_3456_789A);
        chk("collision count", 64'(shift_count), 64'd0);
        chk("collision strobe", 64'(shift_strobe), 64'h0);

        resetn = 0;
        tick(0, 0);
        resetn = 1; mode = 2'b10; data_in = 0; div_ratio = 0;
        repeat (16) tick(1, 0);
        tick(0, 0);
        chk("lfsr par_out", 64'(par_out), LFSR_ON ? 64'h8723 : 64'h0);
        chk("lfsr count", 64'(shift_count), 64'd16);

        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
